// File: rtl/pad_gpio_pkg.sv
// pad_gpio_pkg: shared definitions for the GPIO pad controller.
//   reg_addr_e : register map (DIR, OUT, IRQ_EN, IRQ_STATUS)
//   TC_W       : width of the per-pin turnaround counter
//   tc_load()  : value loaded into the turnaround counter on an out->in switch
// Optional build macro: PAD_GPIO_GLITCH_FILTER_EN (3-sample input glitch filter).
package pad_gpio_pkg;

  localparam int TC_W = 4;

  typedef enum logic [1:0] {
    REG_DIR        = 2'd0,
    REG_OUT        = 2'd1,
    REG_IRQ_EN     = 2'd2,
    REG_IRQ_STATUS = 2'd3
  } reg_addr_e;

`ifdef PAD_GPIO_GLITCH_FILTER_EN
  // The filter delays PIN_IN by two extra cycles; the guard window is
  // stretched by the same amount so it still covers the delayed input.
  localparam int FILT_EXTRA = 2;
`else
  localparam int FILT_EXTRA = 0;
`endif

  // Turnaround load value, saturated to the counter range.
  function automatic logic [TC_W-1:0] tc_load(input int turn_cyc);
    int v;
    v = turn_cyc + FILT_EXTRA;
    if (v > (1 << TC_W) - 1) v = (1 << TC_W) - 1;
    return v[TC_W-1:0];
  endfunction

endpackage

// File: rtl/pad_gpio_pin.sv
// pad_gpio_pin: per-pin input path of the GPIO pad controller.
//   clk, rst   : clock, asynchronous active-high reset
//   pad_o      : raw level from the pad O pin
//   tc_load_en : DIR for this pin was just cleared 1->0 (start turnaround guard)
//   tc_clr     : DIR for this pin was just set 0->1 (cancel turnaround guard)
//   pin_in     : synchronized (and optionally filtered) input level
//   edge_det   : rising or falling edge seen on pin_in, outside the guard window
// Optional build macro: PAD_GPIO_GLITCH_FILTER_EN adds a 3-sample agreement
// filter after the synchronizer (pad->pin_in latency 4 instead of 2).
module pad_gpio_pin
  import pad_gpio_pkg::*;
#(
  parameter int TURN_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_o,
  input  logic tc_load_en,
  input  logic tc_clr,
  output logic pin_in,
  output logic edge_det
);

  localparam logic [TC_W-1:0] TC_INIT = tc_load(TURN_CYC);

  logic            s1;
  logic            s2;
  logic            s_prev;
  logic [TC_W-1:0] tc;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its source; blocking here would collapse the
  // two-flop synchronizer into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad_o;
      s2 <= s1;
    end
  end

`ifdef PAD_GPIO_GLITCH_FILTER_EN
  logic h0;
  logic h1;
  logic held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0   <= 1'b0;
      h1   <= 1'b0;
      held <= 1'b0;
    end else begin
      h0   <= s2;
      h1   <= h0;
      held <= pin_in;
    end
  end

  // Output follows the synchronized level only once three consecutive
  // samples agree; otherwise the last accepted level is held.
  always_comb begin
    pin_in = held;
    if (s2 & h0 & h1)         pin_in = 1'b1;
    else if (~(s2 | h0 | h1)) pin_in = 1'b0;
  end
`else
  assign pin_in = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc <= '0;
    end else if (tc_load_en) begin
      tc <= TC_INIT;
    end else if (tc_clr) begin
      tc <= '0;
    end else if (tc != '0) begin
      tc <= tc - 1'b1;
    end
  end

  // s_prev keeps tracking pin_in during the guard window, so the level that
  // settled while masked is not reported as an edge when the guard expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_prev <= 1'b0;
    else     s_prev <= pin_in;
  end

  assign edge_det = (pin_in ^ s_prev) & (tc == '0);

endmodule

// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: core-side controller for one bank of bidirectional pads.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en_i    : single-cycle register write strobe
//   addr_i     : 0=DIR, 1=OUT (reads return PIN_IN), 2=IRQ_EN, 3=IRQ_STATUS (W1C)
//   wdata_i    : write data
//   rdata_o    : combinational read of the addressed register
//   pad_ie_o   : pad input enable (always on, so driven levels read back)
//   pad_oen_o  : pad output enable, active low (= ~DIR, registered)
//   pad_i_o    : pad output level (= OUT, registered)
//   pad_o_i    : pad input level
//   irq_o      : registered OR of IRQ_STATUS & IRQ_EN
// Optional build macro: PAD_GPIO_GLITCH_FILTER_EN (see pad_gpio_pin).
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int NPINS    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [1:0]       addr_i,
  input  logic [NPINS-1:0] wdata_i,
  output logic [NPINS-1:0] rdata_o,
  output logic [NPINS-1:0] pad_ie_o,
  output logic [NPINS-1:0] pad_oen_o,
  output logic [NPINS-1:0] pad_i_o,
  input  logic [NPINS-1:0] pad_o_i,
  output logic             irq_o
);

  reg_addr_e        addr;
  logic [NPINS-1:0] oen_q;
  logic [NPINS-1:0] out_q;
  logic [NPINS-1:0] irq_en_q;
  logic [NPINS-1:0] irq_sts_q;
  logic [NPINS-1:0] dir;
  logic [NPINS-1:0] pin_in;
  logic [NPINS-1:0] edge_det;
  logic [NPINS-1:0] w1c;
  logic             wr_dir;
  logic             wr_out;
  logic             wr_irq_en;
  logic             wr_irq_sts;

  assign addr       = reg_addr_e'(addr_i);
  assign wr_dir     = wr_en_i && (addr == REG_DIR);
  assign wr_out     = wr_en_i && (addr == REG_OUT);
  assign wr_irq_en  = wr_en_i && (addr == REG_IRQ_EN);
  assign wr_irq_sts = wr_en_i && (addr == REG_IRQ_STATUS);
  assign w1c        = wr_irq_sts ? wdata_i : '0;

  // DIR is stored inverted so the pad OEN comes straight from a flop that
  // resets to "all released" without any post-flop logic.
  assign dir = ~oen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oen_q     <= '1;
      out_q     <= '0;
      irq_en_q  <= '0;
      irq_sts_q <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_dir)    oen_q    <= ~wdata_i;
      if (wr_out)    out_q    <= wdata_i;
      if (wr_irq_en) irq_en_q <= wdata_i;
      // A new edge in the same cycle as its W1C wins over the clear.
      irq_sts_q <= (irq_sts_q & ~w1c) | edge_det;
      irq_o     <= |(irq_sts_q & irq_en_q);
    end
  end

  assign pad_ie_o  = '1;
  assign pad_oen_o = oen_q;
  assign pad_i_o   = out_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    rdata_o = '0;
    case (addr)
      REG_DIR:        rdata_o = dir;
      REG_OUT:        rdata_o = pin_in;
      REG_IRQ_EN:     rdata_o = irq_en_q;
      REG_IRQ_STATUS: rdata_o = irq_sts_q;
      default:        rdata_o = '0;
    endcase
  end

  for (genvar k = 0; k < NPINS; k++) begin : g_pin
    pad_gpio_pin #(
      .TURN_CYC (TURN_CYC)
    ) u_pin (
      .clk        (clk),
      .rst        (rst),
      .pad_o      (pad_o_i[k]),
      .tc_load_en (wr_dir & dir[k] & ~wdata_i[k]),
      .tc_clr     (wr_dir & ~dir[k] & wdata_i[k]),
      .pin_in     (pin_in[k]),
      .edge_det   (edge_det[k])
    );
  end

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// tb_pad_gpio_ctrl: directed self-checking bench for pad_gpio_ctrl
// (NPINS=8, TURN_CYC=2). Inputs change and outputs are sampled 1ns after the
// rising edge. Honours PAD_GPIO_GLITCH_FILTER_EN for input latency and the
// filter scenario.
module tb_pad_gpio_ctrl;

  localparam int NP = 8;
  localparam int TC = 2;
`ifdef PAD_GPIO_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [NP-1:0] wdata = '0;
  logic [NP-1:0] rdata;
  logic [NP-1:0] pad_ie;
  logic [NP-1:0] pad_oen;
  logic [NP-1:0] pad_i;
  logic [NP-1:0] pad_o = '0;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  pad_gpio_ctrl #(.NPINS(NP), .TURN_CYC(TC)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .pad_ie_o  (pad_ie),
    .pad_oen_o (pad_oen),
    .pad_i_o   (pad_i),
    .pad_o_i   (pad_o),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [NP-1:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [NP-1:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [NP-1:0] v;
    tick(2);
    n_vec++; if (pad_oen !== 8'hFF) begin n_err++; $display("FAIL por_oen: got %h want ff", pad_oen); end
    n_vec++; if (pad_i !== 8'h00) begin n_err++; $display("FAIL por_pad_i: got %h want 00", pad_i); end
    n_vec++; if (pad_ie !== 8'hFF) begin n_err++; $display("FAIL por_ie: got %h want ff", pad_ie); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL por_irq: got %b want 0", irq); end
    rst = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL por_rdata[%0d]: got %h want 00", a, v); end
    end
    // Mid-run reset with all pins driving and an interrupt pending.
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hFF);
    pad_o = 8'hFF;
    wr(2'd2, 8'hFF);
    tick(LAT + 2);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    n_vec++; if (pad_oen !== 8'h00) begin n_err++; $display("FAIL pre_rst_oen: got %h want 00", pad_oen); end
    pad_o = 8'h00;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (pad_oen !== 8'hFF) begin n_err++; $display("FAIL rst_oen: got %h want ff", pad_oen); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_vec++; if (pad_i !== 8'h00) begin n_err++; $display("FAIL rst_pad_i: got %h want 00", pad_i); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL rst_rdata[%0d]: got %h want 00", a, v); end
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_output_drive();
    logic [NP-1:0] v;
    wr(2'd0, 8'h0F);
    n_vec++; if (pad_oen !== 8'hF0) begin n_err++; $display("FAIL drv_oen: got %h want f0", pad_oen); end
    wr(2'd1, 8'h05);
    n_vec++; if (pad_i !== 8'h05) begin n_err++; $display("FAIL drv_pad_i: got %h want 05", pad_i); end
    pad_o = 8'h05;
    tick();
    rd(2'd1, v);
    n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL drv_early_in: got %h want 00", v); end
    tick(LAT - 1);
    rd(2'd1, v);
    n_vec++; if (v !== 8'h05) begin n_err++; $display("FAIL drv_loopback: got %h want 05", v); end
    rd(2'd0, v);
    n_vec++; if (v !== 8'h0F) begin n_err++; $display("FAIL drv_dir_rd: got %h want 0f", v); end
    tick();
    rd(2'd3, v);
    n_vec++; if (v !== 8'h05) begin n_err++; $display("FAIL drv_own_edges: got %h want 05", v); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL drv_irq_masked: got %b want 0", irq); end
    // Return to an idle bank: all inputs, pads low, status clear.
    wr(2'd1, 8'h00);
    pad_o = 8'h00;
    wr(2'd0, 8'h00);
    tick(LAT + 6);
    wr(2'd3, 8'hFF);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL drv_cleanup: got %h want 00", v); end
  endtask

  task automatic test_input_edge_irq();
    logic [NP-1:0] v;
    wr(2'd2, 8'h01);
    pad_o[0] = 1'b1;
    tick(LAT);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL edge_early: got %h want 00", v); end
    tick();
    rd(2'd3, v);
    n_vec++; if (v !== 8'h01) begin n_err++; $display("FAIL edge_sts: got %h want 01", v); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_early: got %b want 0", irq); end
    tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq: got %b want 1", irq); end
    wr(2'd3, 8'h01);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL edge_w1c: got %h want 00", v); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_hold: got %b want 1", irq); end
    tick();
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_turnaround();
    logic [NP-1:0] v;
    wr(2'd0, 8'h04);
    wr(2'd1, 8'h04);
    pad_o[2] = 1'b1;
    tick(LAT + 1);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h04) begin n_err++; $display("FAIL ta_out_edge: got %h want 04", v); end
    wr(2'd3, 8'h04);
    // Switch pin 2 back to input while the pad is released low.
    pad_o[2] = 1'b0;
    wr(2'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd(2'd3, v);
      n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL ta_masked[%0d]: got %h want 00", i, v); end
      tick();
    end
    rd(2'd1, v);
    n_vec++; if (v[2] !== 1'b0) begin n_err++; $display("FAIL ta_pin_low: got %b want 0", v[2]); end
    // Detection resumes once the guard has expired.
    pad_o[2] = 1'b1;
    tick(LAT + 1);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h04) begin n_err++; $display("FAIL ta_resume: got %h want 04", v); end
    wr(2'd1, 8'h00);
    pad_o[2] = 1'b0;
    tick(LAT + 2);
    wr(2'd3, 8'hFF);
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] v;
    pad_o[1] = 1'b1;
    tick(LAT + 1);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h02) begin n_err++; $display("FAIL b2b_set: got %h want 02", v); end
    pad_o[1] = 1'b0;
    tick(LAT);
    wr(2'd3, 8'h02);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h02) begin n_err++; $display("FAIL b2b_set_wins: got %h want 02", v); end
    wr(2'd3, 8'h02);
    rd(2'd3, v);
    n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL b2b_clear: got %h want 00", v); end
  endtask

`ifdef PAD_GPIO_GLITCH_FILTER_EN
  task automatic test_filter();
    logic [NP-1:0] v;
    wr(2'd2, 8'h08);
    pad_o[3] = 1'b1;
    tick(2);
    pad_o[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(2'd1, v);
      n_vec++; if (v[3] !== 1'b0) begin n_err++; $display("FAIL flt_glitch_in[%0d]: got %b want 0", i, v[3]); end
      rd(2'd3, v);
      n_vec++; if (v[3] !== 1'b0) begin n_err++; $display("FAIL flt_glitch_sts[%0d]: got %b want 0", i, v[3]); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL flt_glitch_irq[%0d]: got %b want 0", i, irq); end
      tick();
    end
    pad_o[3] = 1'b1;
    tick(3);
    rd(2'd1, v);
    n_vec++; if (v[3] !== 1'b0) begin n_err++; $display("FAIL flt_pulse_early: got %b want 0", v[3]); end
    tick();
    rd(2'd1, v);
    n_vec++; if (v[3] !== 1'b1) begin n_err++; $display("FAIL flt_pulse_in: got %b want 1", v[3]); end
    pad_o[3] = 1'b0;
    tick();
    rd(2'd3, v);
    n_vec++; if (v[3] !== 1'b1) begin n_err++; $display("FAIL flt_pulse_sts: got %b want 1", v[3]); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_output_drive();
    test_input_edge_irq();
    test_turnaround();
    test_back_to_back();
`ifdef PAD_GPIO_GLITCH_FILTER_EN
    test_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
